seg7_count_display: RTL and testbench



---
 rtl/seg7_count_display.sv | 174 +++++++++++++++++
 tb/tb_seg7_count_display.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_count_display.sv
// Binary-to-BCD conversion (sequential double-dabble) driving a multiplexed common-anode 7-segment display.
// Optional leading-zero blanking is compiled in when the LZB_EN macro is defined.
module seg7_count_display #(
    parameter int N        = 7,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          value_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  conv_done,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int SW       = 4 * DIGITS + 4;
    localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam int PRESC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int MAX_DISP = 10 ** DIGITS - 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Conversion datapath state
    state_e             state_q;
    logic [N-1:0]       shift_q, shift_d;
    logic [N-1:0]       value_q;
    logic [SW-1:0]      scratch_q, scratch_d, scratch_adj;
    logic [CNT_W-1:0]   bitcnt_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic               done_q;
    logic               ovf_q;

    // NOTE: every variable written in always_comb is given a default first, so no latch is inferred.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < SW / 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            value_q   <= '0;
            scratch_q <= '0;
            bitcnt_q  <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    shift_q   <= value_in;
                    value_q   <= value_in;
                    scratch_q <= '0;
                    bitcnt_q  <= CNT_W'(N - 1);
                    state_q   <= SHIFT;
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    bitcnt_q  <= bitcnt_q - CNT_W'(1);
                    if (bitcnt_q == '0) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    ovf_q   <= (32'(value_q) > 32'(MAX_DISP));
                    bcd_q   <= scratch_q[4*DIGITS-1:0];
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Scan datapath state
    logic [PRESC_W-1:0] presc_q;
    logic [IDX_W-1:0]   digit_q, digit_d;
    logic               started_q;
    logic [6:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic [3:0]         nibble;
    logic               blank;
    logic               tick;

    assign tick = (presc_q == PRESC_W'(SCAN_DIV - 1));

    // The very first tick after reset selects digit 0 instead of advancing.
    always_comb begin
        digit_d = (!started_q || digit_q == IDX_W'(DIGITS - 1)) ? '0 : digit_q + IDX_W'(1);
        nibble  = 4'd0;
        an_d    = '1;
`ifdef LZB_EN
        blank   = (digit_d != '0);
`else
        blank   = 1'b0;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_d == IDX_W'(i)) begin
                nibble  = bcd_q[4*i +: 4];
                an_d[i] = 1'b0;
            end
`ifdef LZB_EN
            if (IDX_W'(i) >= digit_d && bcd_q[4*i +: 4] != 4'd0) begin
                blank = 1'b0;
            end
`endif
        end
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (blank) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(nibble);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            digit_q   <= '0;
            started_q <= 1'b0;
            seg_q     <= SEG_BLANK;
            an_q      <= '1;
        end else if (tick) begin
            presc_q   <= '0;
            digit_q   <= digit_d;
            started_q <= 1'b1;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end else begin
            presc_q   <= presc_q + PRESC_W'(1);
        end
    end

    assign bcd_out   = bcd_q;
    assign conv_done = done_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule

// File: tb/tb_seg7_count_display.sv
// Self-checking bench for seg7_count_display: N=7 and N=10 instances, SCAN_DIV=4, randomized stimulus vs. arithmetic model.
module tb_seg7_count_display;

    localparam int N1       = 7;
    localparam int N2       = 10;
    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N1-1:0]      val1 = '0;
    logic [N2-1:0]      val2 = '0;
    logic [11:0]        bcd1, bcd2;
    logic               done1, done2;
    logic [6:0]         seg1, seg2;
    logic [2:0]         an1, an2;

    int tests = 0;
    int fails = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    seg7_count_display #(.N(N1), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .value_in(val1), .bcd_out(bcd1),
        .conv_done(done1), .seg(seg1), .an(an1)
    );

    seg7_count_display #(.N(N2), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut_ovf (
        .clk(clk), .rst_n(rst_n), .value_in(val2), .bcd_out(bcd2),
        .conv_done(done2), .seg(seg2), .an(an2)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] model_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    function automatic logic [6:0] model_seg(input int v, input int k);
        if (v > 10 ** DIGITS - 1) return 7'b0111111;
`ifdef LZB_EN
        if (k > 0 && v < 10 ** k) return 7'b1111111;
`endif
        return seg_tab[(v / (10 ** k)) % 10];
    endfunction

    task automatic wait_done(input bit sel, output int cycles);
        cycles = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if ((sel ? done2 : done1) === 1'b1) begin
                cycles = i;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL wait_done(dut%0d): no conv_done within 40 cycles", sel);
    endtask

    task automatic get_slot(input bit sel, output logic [2:0] a, output logic [6:0] s);
        logic [2:0] old;
        old = sel ? an2 : an1;
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            @(negedge clk);
            if ((sel ? an2 : an1) !== old) begin
                a = sel ? an2 : an1;
                s = sel ? seg2 : seg1;
                return;
            end
        end
        a = sel ? an2 : an1;
        s = sel ? seg2 : seg1;
        tests++;
        fails++;
        $display("FAIL get_slot(dut%0d): an stuck at %b", sel, a);
    endtask

    task automatic check_slots(input bit sel, input int v, input int n, input string name);
        logic [2:0] a;
        logic [6:0] s, exp_s;
        int idx, exp_idx, prev;
        prev = -1;
        for (int j = 0; j < n; j++) begin
            get_slot(sel, a, s);
            idx = -1;
            for (int b = 0; b < 3; b++) if (a === ~(3'b001 << b)) idx = b;
            exp_idx = (prev < 0) ? idx : (prev + 1) % 3;
            tests++;
            if (idx < 0 || idx != exp_idx) begin
                fails++;
                $display("FAIL %s an slot%0d: got %b, required active-low digit %0d", name, j, a, exp_idx);
            end
            exp_s = model_seg(v, (exp_idx < 0) ? 0 : exp_idx);
            tests++;
            if (s !== exp_s) begin
                fails++;
                $display("FAIL %s seg digit%0d: got %b, required %b", name, exp_idx, s, exp_s);
            end
            prev = exp_idx;
        end
    endtask

    task automatic test_reset();
        int c;
        repeat (2) @(negedge clk);
        val1 = 7'd100;
        tests += 4;
        if (seg1 !== 7'h7F) begin fails++; $display("FAIL reset seg: got %h, required 7f", seg1); end
        if (an1 !== 3'b111) begin fails++; $display("FAIL reset an: got %b, required 111", an1); end
        if (bcd1 !== 12'h0) begin fails++; $display("FAIL reset bcd: got %h, required 000", bcd1); end
        if (done1 !== 1'b0) begin fails++; $display("FAIL reset done: got %b, required 0", done1); end
        rst_n = 1'b1;
        wait_done(0, c);
        tests += 2;
        if (c != 9) begin fails++; $display("FAIL reset first_done latency: got %0d, required 9", c); end
        if (bcd1 !== 12'h100) begin fails++; $display("FAIL reset first bcd: got %h, required 100", bcd1); end
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (an1 === 3'b111) begin fails++; $display("FAIL reset pre_abort an: got %b, required a driven digit", an1); end
        rst_n = 1'b0;
        #1;
        tests += 4;
        if (seg1 !== 7'h7F) begin fails++; $display("FAIL async seg: got %h, required 7f", seg1); end
        if (an1 !== 3'b111) begin fails++; $display("FAIL async an: got %b, required 111", an1); end
        if (bcd1 !== 12'h0) begin fails++; $display("FAIL async bcd: got %h, required 000", bcd1); end
        if (done1 !== 1'b0) begin fails++; $display("FAIL async done: got %b, required 0", done1); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                tests++;
                if (an1 !== 3'b111) begin fails++; $display("FAIL release pre_tick an: got %b, required 111", an1); end
            end
            if (i == 4) begin
                tests += 2;
                if (an1 !== 3'b110) begin fails++; $display("FAIL release first_tick an: got %b, required 110", an1); end
                if (seg1 !== 7'b1000000) begin fails++; $display("FAIL release first_tick seg: got %b, required 1000000", seg1); end
            end
            if (i < 9) begin
                tests++;
                if (done1 !== 1'b0) begin fails++; $display("FAIL release early done at cycle %0d: got 1, required 0", i); end
            end
        end
        tests += 2;
        if (done1 !== 1'b1) begin fails++; $display("FAIL release done@9: got %b, required 1", done1); end
        if (bcd1 !== 12'h100) begin fails++; $display("FAIL release bcd: got %h, required 100", bcd1); end
    endtask

    task automatic test_full_range();
        int c;
        val1 = 7'd127;
        wait_done(0, c);
        wait_done(0, c);
        tests++;
        if (bcd1 !== 12'h127) begin fails++; $display("FAIL full_range bcd: got %h, required 127", bcd1); end
        check_slots(0, 127, 6, "full_range");
    endtask

    task automatic test_sweep();
        int c;
        for (int v = 0; v < 128; v++) begin
            repeat ($urandom_range(0, 9)) @(posedge clk);
            #1;
            val1 = 7'(v);
            wait_done(0, c);
            wait_done(0, c);
            tests += 2;
            if (c != 9) begin fails++; $display("FAIL sweep period v=%0d: got %0d, required 9", v, c); end
            if (bcd1 !== model_bcd(v)) begin
                fails++;
                $display("FAIL sweep bcd v=%0d: got %h, required %h", v, bcd1, model_bcd(v));
            end
        end
    endtask

    task automatic test_leading_zeros();
        int c;
        int vals [2] = '{7, 0};
        foreach (vals[i]) begin
            val1 = 7'(vals[i]);
            wait_done(0, c);
            wait_done(0, c);
            check_slots(0, vals[i], 3, "leading_zeros");
        end
    endtask

    task automatic test_random_scan();
        int c, v;
        for (int r = 0; r < 6; r++) begin
            v = $urandom_range(0, 127);
            val1 = 7'(v);
            wait_done(0, c);
            wait_done(0, c);
            tests++;
            if (bcd1 !== model_bcd(v)) begin
                fails++;
                $display("FAIL random bcd v=%0d: got %h, required %h", v, bcd1, model_bcd(v));
            end
            check_slots(0, v, 3, "random_scan");
        end
    endtask

    task automatic test_overflow();
        int c, v;
        for (int r = 0; r < 3; r++) begin
            v = (r == 0) ? 1000 : $urandom_range(1000, 1023);
            val2 = 10'(v);
            wait_done(1, c);
            wait_done(1, c);
            check_slots(1, v, 3, "overflow");
        end
        @(posedge clk);
        #1;
        val2 = 10'd999;
        repeat (24) @(posedge clk);
        #1;
        tests++;
        if (bcd2 !== 12'h999) begin fails++; $display("FAIL overflow_recover bcd: got %h, required 999", bcd2); end
        check_slots(1, 999, 3, "overflow_recover");
    endtask

    task automatic test_mid_change();
        int c;
        val1 = 7'd5;
        wait_done(0, c);
        wait_done(0, c);
        @(posedge clk);
        #1;
        val1 = 7'd6;
        wait_done(0, c);
        tests++;
        if (bcd1 !== 12'h005) begin fails++; $display("FAIL mid_change first bcd: got %h, required 005", bcd1); end
        wait_done(0, c);
        tests++;
        if (bcd1 !== 12'h006) begin fails++; $display("FAIL mid_change second bcd: got %h, required 006", bcd1); end
    endtask

    initial begin
        test_reset();
        test_full_range();
        test_sweep();
        test_leading_zeros();
        test_random_scan();
        test_overflow();
        test_mid_change();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
